// File: rtl/segment_pipe_reg.sv
// Parametrised pipeline segment register: DEPTH stages of {valid, ctrl, data},
// with stall/flush control, registered occupancy and saturating event counters.
module segment_pipe_reg #(
  parameter int CTRL_W = 12,
  parameter int DATA_W = 108,
  parameter int DEPTH  = 1,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              flush_i,
  input  logic              valid_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic [DATA_W-1:0] data_i,
  output logic              valid_o,
  output logic [CTRL_W-1:0] ctrl_o,
  output logic [DATA_W-1:0] data_o,
  output logic [3:0]        occ_o,
  output logic [CNT_W-1:0]  stall_cnt_o,
  output logic [CNT_W-1:0]  flush_cnt_o
);

  logic [DEPTH-1:0]             validQ, validD;
  logic [DEPTH-1:0][CTRL_W-1:0] ctrlQ, ctrlD;
  logic [DEPTH-1:0][DATA_W-1:0] dataQ, dataD;
  logic [3:0]                   occQ, occD;
  logic [CNT_W-1:0]             stallCnt, flushCnt;

  always_comb begin
    validD = validQ;
    ctrlD  = ctrlQ;
    dataD  = dataQ;
    if (flush_i) begin
      // Bubbles keep their data payload; only valid and control are cleared.
      validD = '0;
      ctrlD  = '0;
    end else if (!stall_i) begin
      validD[0] = valid_i;
      ctrlD[0]  = valid_i ? ctrl_i : '0;
      dataD[0]  = data_i;
      for (int unsigned k = 1; k < DEPTH; k++) begin
        validD[k] = validQ[k-1];
        ctrlD[k]  = ctrlQ[k-1];
        dataD[k]  = dataQ[k-1];
      end
    end
    occD = 4'($countones(validD));
  end

  always_ff @(negedge clk or negedge rst) begin
    if (!rst) begin
      validQ   <= '0;
      ctrlQ    <= '0;
      dataQ    <= '0;
      occQ     <= '0;
      stallCnt <= '0;
      flushCnt <= '0;
    end else begin
      validQ <= validD;
      ctrlQ  <= ctrlD;
      dataQ  <= dataD;
      occQ   <= occD;
      if (flush_i) begin
        if (flushCnt != '1) flushCnt <= flushCnt + CNT_W'(1);
      end else if (stall_i) begin
        if (stallCnt != '1) stallCnt <= stallCnt + CNT_W'(1);
      end
    end
  end

  assign valid_o     = validQ[DEPTH-1];
  assign ctrl_o      = validQ[DEPTH-1] ? ctrlQ[DEPTH-1] : '0;
  assign data_o      = dataQ[DEPTH-1];
  assign occ_o       = occQ;
  assign stall_cnt_o = stallCnt;
  assign flush_cnt_o = flushCnt;

endmodule

// File: tb/tb_segment_pipe_reg.sv
// Directed bench for segment_pipe_reg: three instances (DEPTH 1, 2, 3/CNT_W 4)
// share stimulus; each scenario checks the instance it targets.
module tb_segment_pipe_reg;

  logic         clk = 1'b1;
  logic         rst = 1'b0;
  logic         stall = 1'b0, flush = 1'b0, valid = 1'b0;
  logic [11:0]  ctrl = '0;
  logic [107:0] data = '0;

  logic v1, v2, v3;
  logic [11:0]  c1, c2, c3;
  logic [107:0] d1, d2, d3;
  logic [3:0]   o1, o2, o3;
  logic [15:0]  s1, f1, s2, f2;
  logic [3:0]   s3, f3;

  int nTests = 0;
  int nFail  = 0;

  always #5 clk = ~clk;

  segment_pipe_reg #(.CTRL_W(12), .DATA_W(108), .DEPTH(1), .CNT_W(16)) u1 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .data_i(data), .valid_o(v1), .ctrl_o(c1), .data_o(d1),
    .occ_o(o1), .stall_cnt_o(s1), .flush_cnt_o(f1));

  segment_pipe_reg #(.CTRL_W(12), .DATA_W(108), .DEPTH(2), .CNT_W(16)) u2 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .data_i(data), .valid_o(v2), .ctrl_o(c2), .data_o(d2),
    .occ_o(o2), .stall_cnt_o(s2), .flush_cnt_o(f2));

  segment_pipe_reg #(.CTRL_W(12), .DATA_W(108), .DEPTH(3), .CNT_W(4)) u3 (
    .clk(clk), .rst(rst), .stall_i(stall), .flush_i(flush), .valid_i(valid),
    .ctrl_i(ctrl), .data_i(data), .valid_o(v3), .ctrl_o(c3), .data_o(d3),
    .occ_o(o3), .stall_cnt_o(s3), .flush_cnt_o(f3));

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b0; stall = 1'b0; flush = 1'b0; valid = 1'b0; ctrl = '0; data = '0;
    tick();
    rst = 1'b1;
  endtask

  task automatic drive(input logic v, input logic [11:0] c, input logic [107:0] d);
    valid = v; ctrl = c; data = d;
  endtask

  task automatic test_reset();
    doReset();
    nTests++; if ({v1, c1, o1, s1, f1} !== '0) begin nFail++; $display("FAIL reset_u1: got v=%b c=%h o=%0d s=%0d f=%0d required all 0", v1, c1, o1, s1, f1); end
    nTests++; if (d1 !== '0) begin nFail++; $display("FAIL reset_u1_data: got %h required 0", d1); end
    nTests++; if ({v2, c2, o2, s2, f2} !== '0 || d2 !== '0) begin nFail++; $display("FAIL reset_u2: got v=%b c=%h d=%h o=%0d required 0", v2, c2, d2, o2); end
    nTests++; if ({v3, c3, o3, s3, f3} !== '0 || d3 !== '0) begin nFail++; $display("FAIL reset_u3: got v=%b c=%h d=%h o=%0d required 0", v3, c3, d3, o3); end
  endtask

  task automatic test_depth1();
    doReset();
    drive(1'b1, 12'h0A5, 108'h1234);
    tick();
    nTests++; if (v1 !== 1'b1) begin nFail++; $display("FAIL d1_valid: got %b required 1", v1); end
    nTests++; if (c1 !== 12'h0A5) begin nFail++; $display("FAIL d1_ctrl: got %h required 0a5", c1); end
    nTests++; if (d1 !== 108'h1234) begin nFail++; $display("FAIL d1_data: got %h required 1234", d1); end
    nTests++; if (o1 !== 4'd1) begin nFail++; $display("FAIL d1_occ: got %0d required 1", o1); end
  endtask

  task automatic test_stall();
    doReset();
    drive(1'b1, 12'h001, 108'h1); tick();
    nTests++; if (v3 !== 1'b0 || o3 !== 4'd1) begin nFail++; $display("FAIL stall_e1: got v=%b occ=%0d required v=0 occ=1", v3, o3); end
    drive(1'b1, 12'h002, 108'h2); tick();
    nTests++; if (v3 !== 1'b0 || o3 !== 4'd2) begin nFail++; $display("FAIL stall_e2: got v=%b occ=%0d required v=0 occ=2", v3, o3); end
    drive(1'b1, 12'h003, 108'h3); tick();
    nTests++; if (v3 !== 1'b1 || c3 !== 12'h001 || d3 !== 108'h1 || o3 !== 4'd3) begin nFail++; $display("FAIL stall_e3: got v=%b c=%h d=%h occ=%0d required 1/001/1/3", v3, c3, d3, o3); end
    stall = 1'b1; drive(1'b1, 12'h004, 108'h4);
    for (int i = 1; i <= 2; i++) begin
      tick();
      nTests++; if (v3 !== 1'b1 || c3 !== 12'h001 || d3 !== 108'h1 || o3 !== 4'd3 || s3 !== 4'(i)) begin nFail++; $display("FAIL stall_hold%0d: got v=%b c=%h d=%h occ=%0d scnt=%0d required 1/001/1/3/%0d", i, v3, c3, d3, o3, s3, i); end
    end
    stall = 1'b0; drive(1'b0, 12'hFFF, 108'hBEEF); tick();
    nTests++; if (v3 !== 1'b1 || c3 !== 12'h002 || d3 !== 108'h2 || o3 !== 4'd2) begin nFail++; $display("FAIL stall_resume: got v=%b c=%h d=%h occ=%0d required 1/002/2/2", v3, c3, d3, o3); end
    tick();
    nTests++; if (c3 !== 12'h003 || o3 !== 4'd1) begin nFail++; $display("FAIL stall_drain: got c=%h occ=%0d required 003/1", c3, o3); end
    tick();
    nTests++; if (v3 !== 1'b0 || c3 !== 12'h000 || d3 !== 108'hBEEF || o3 !== 4'd0) begin nFail++; $display("FAIL bubble_in: got v=%b c=%h d=%h occ=%0d required 0/000/beef/0", v3, c3, d3, o3); end
    nTests++; if (s3 !== 4'd2 || f3 !== 4'd0) begin nFail++; $display("FAIL stall_cnts: got s=%0d f=%0d required 2/0", s3, f3); end
  endtask

  task automatic test_flush();
    doReset();
    drive(1'b1, 12'h00A, 108'h100); tick();
    drive(1'b1, 12'h00B, 108'h200); tick();
    drive(1'b1, 12'h00C, 108'h300); tick();
    nTests++; if (o3 !== 4'd3 || d3 !== 108'h100) begin nFail++; $display("FAIL flush_pre: got occ=%0d d=%h required 3/100", o3, d3); end
    flush = 1'b1; stall = 1'b1; drive(1'b1, 12'h007, 108'h999); tick();
    nTests++; if (v3 !== 1'b0 || c3 !== 12'h000 || o3 !== 4'd0) begin nFail++; $display("FAIL flush_out: got v=%b c=%h occ=%0d required 0/000/0", v3, c3, o3); end
    nTests++; if (f3 !== 4'd1 || s3 !== 4'd0) begin nFail++; $display("FAIL flush_cnts: got f=%0d s=%0d required 1/0", f3, s3); end
    nTests++; if (d3 !== 108'h100) begin nFail++; $display("FAIL flush_data: got %h required 100", d3); end
    flush = 1'b0; stall = 1'b0; drive(1'b0, 12'h000, 108'h0); tick();
    nTests++; if (v3 !== 1'b0 || d3 !== 108'h200 || o3 !== 4'd0) begin nFail++; $display("FAIL flush_shift: got v=%b d=%h occ=%0d required 0/200/0", v3, d3, o3); end
  endtask

  task automatic test_saturate();
    doReset();
    stall = 1'b1;
    for (int i = 0; i < 15; i++) tick();
    nTests++; if (s3 !== 4'd15) begin nFail++; $display("FAIL sat_15: got %0d required 15", s3); end
    for (int i = 0; i < 5; i++) tick();
    nTests++; if (s3 !== 4'd15) begin nFail++; $display("FAIL sat_20: got %0d required 15", s3); end
    nTests++; if (s1 !== 16'd20) begin nFail++; $display("FAIL wide_cnt: got %0d required 20", s1); end
    stall = 1'b0;
  endtask

  task automatic test_async_reset();
    doReset();
    drive(1'b1, 12'h011, 108'h11); tick();
    drive(1'b1, 12'h022, 108'h22); tick();
    stall = 1'b1; tick(); stall = 1'b0;
    nTests++; if (o2 !== 4'd2 || v2 !== 1'b1 || s2 !== 16'd1) begin nFail++; $display("FAIL ar_pre: got occ=%0d v=%b s=%0d required 2/1/1", o2, v2, s2); end
    #2 rst = 1'b0;
    #1;
    nTests++; if ({v2, c2, o2, s2, f2} !== '0 || d2 !== '0) begin nFail++; $display("FAIL ar_clear: got v=%b c=%h d=%h occ=%0d s=%0d required all 0", v2, c2, d2, o2, s2); end
    drive(1'b1, 12'h055, 108'h55);
    rst = 1'b1;
    tick();
    nTests++; if (o2 !== 4'd1 || v2 !== 1'b0) begin nFail++; $display("FAIL ar_first: got occ=%0d v=%b required 1/0", o2, v2); end
    drive(1'b0, 12'h000, 108'h0); tick();
    nTests++; if (v2 !== 1'b1 || c2 !== 12'h055 || d2 !== 108'h55) begin nFail++; $display("FAIL ar_out: got v=%b c=%h d=%h required 1/055/55", v2, c2, d2); end
  endtask

  initial begin
    test_reset();
    test_depth1();
    test_stall();
    test_flush();
    test_saturate();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end

endmodule
